// File: rtl/baud_tick_gen_pkg.sv
// Shared baud definitions: select codes, rate table and the phase-increment helper used by
// the tick generator, the tx/rx shifters and their benches.
package baud_tick_gen_pkg;

   typedef enum logic [2:0] {
      BAUD_300    = 3'b000,
      BAUD_1200   = 3'b001,
      BAUD_4800   = 3'b010,
      BAUD_9600   = 3'b011,
      BAUD_19200  = 3'b100,
      BAUD_38400  = 3'b101,
      BAUD_57600  = 3'b110,
      BAUD_115200 = 3'b111
   } baud_sel_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } gen_state_e;

   localparam int unsigned BAUD_RATE [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};

   // round(rate * os * 2^acc_w / clk_hz), all in 64-bit so the 115200 x16 x2^24 product fits.
   function automatic longint unsigned inc_for(input longint unsigned rate,
                                               input longint unsigned clk_hz,
                                               input longint unsigned os,
                                               input int unsigned     acc_w);
      longint unsigned num;
      num = (rate * os) << acc_w;
      return (num + (clk_hz >> 1)) / clk_hz;
   endfunction

endpackage

// File: rtl/baud_tick_gen_phase_acc.sv
// Fractional phase accumulator: adds inc every running cycle and registers the carry-out,
// which becomes the sample tick. wrap is the carry about to be registered this edge.
module baud_phase_acc #(
   parameter int unsigned ACC_W = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [ACC_W-1:0] inc,
   input  logic             clear,
   input  logic             run,
   output logic             carry,
   output logic             wrap
);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic             carry_q, carry_d;
   logic [ACC_W:0]   sum;

   always_comb begin
      sum     = {1'b0, acc_q} + {1'b0, inc};
      acc_d   = acc_q;
      carry_d = 1'b0;
      if (clear) begin
         acc_d = '0;
      end else if (run) begin
         acc_d   = sum[ACC_W-1:0];
         carry_d = sum[ACC_W];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         carry_q <= carry_d;
      end
   end

   assign carry = carry_q;
   assign wrap  = carry_d;

endmodule

// File: rtl/baud_tick_gen.sv
// Shared UART baud divider: one phase accumulator yields oversampled, mid-bit and bit ticks;
// rx re-phases it with sync, and baud changes only take effect on a bit boundary.
module baud_tick_gen
   import baud_tick_gen_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned ACC_W      = 24
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [2:0]                    baud_select,
   input  logic                          sync,
   output logic                          sample_tick,
   output logic                          mid_tick,
   output logic                          bit_tick,
   output logic [$clog2(OVERSAMPLE)-1:0] sample_idx
);

   localparam int unsigned IDX_W = $clog2(OVERSAMPLE);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0] IDX_MID  = IDX_W'(OVERSAMPLE / 2);

   logic [ACC_W-1:0] inc_tbl [8];

   for (genvar gi = 0; gi < 8; gi++) begin : g_inc
      localparam longint unsigned INC_G =
         inc_for(64'(BAUD_RATE[gi]), 64'(CLK_HZ), 64'(OVERSAMPLE), ACC_W);
      if ((INC_G < 64'd1) || (INC_G >= (64'd1 << ACC_W))) begin : g_bad
         $error("baud_tick_gen: phase increment for code %0d out of range", gi);
      end
      assign inc_tbl[gi] = INC_G[ACC_W-1:0];
   end

   gen_state_e       state_q, state_d;
   baud_sel_e        active_sel_q, active_sel_d;
   baud_sel_e        pend_sel_q, pend_sel_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             run_en;
   logic             carry;
   logic             wrap;

   // sync and a falling enable both clear the accumulator on the same edge, so neither ticks.
   assign run_en = (state_q == ST_RUN) && enable && !sync;

   baud_phase_acc #(.ACC_W(ACC_W)) u_acc (
      .clk   (clk),
      .reset (reset),
      .inc   (inc_tbl[active_sel_q]),
      .clear (!run_en),
      .run   (run_en),
      .carry (carry),
      .wrap  (wrap)
   );

   always_comb begin
      state_d      = state_q;
      active_sel_d = active_sel_q;
      pend_sel_d   = pend_sel_q;
      idx_d        = idx_q;
      case (state_q)
         ST_IDLE: begin
            active_sel_d = baud_sel_e'(baud_select);
            pend_sel_d   = baud_sel_e'(baud_select);
            idx_d        = '0;
            if (enable) state_d = ST_RUN;
         end
         ST_RUN: begin
            pend_sel_d = baud_sel_e'(baud_select);
            if (!enable) begin
               state_d = ST_IDLE;
               idx_d   = '0;
            end else if (sync) begin
               idx_d        = '0;
               active_sel_d = pend_sel_q;
            end else if (wrap) begin
               idx_d = idx_q + 1'b1;
               // Rate switch lands exactly on the bit boundary.
               if (idx_q == IDX_LAST) active_sel_d = pend_sel_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         active_sel_q <= BAUD_300;
         pend_sel_q   <= BAUD_300;
         idx_q        <= '0;
      end else begin
         state_q      <= state_d;
         active_sel_q <= active_sel_d;
         pend_sel_q   <= pend_sel_d;
         idx_q        <= idx_d;
      end
   end

   assign sample_tick = carry;
   assign bit_tick    = carry && (idx_q == '0);
   assign mid_tick    = carry && (idx_q == IDX_MID);
   assign sample_idx  = idx_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen at 100 MHz, x16 oversampling, 24-bit accumulator.
module tb_baud_tick_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [2:0] baud_select;
   logic       sync;
   logic       sample_tick;
   logic       mid_tick;
   logic       bit_tick;
   logic [3:0] sample_idx;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   int n_smp, n_mid, n_bit, first_smp, last_smp, gmin, gmax, orphan, idx_err;
   int bit_t[$];
   int mid_t[$];
   int e, s;
   bit found;

   baud_tick_gen #(.CLK_HZ(100_000_000), .OVERSAMPLE(16), .ACC_W(24)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .baud_select (baud_select),
      .sync        (sync),
      .sample_tick (sample_tick),
      .mid_tick    (mid_tick),
      .bit_tick    (bit_tick),
      .sample_idx  (sample_idx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input longint obs, input longint lo, input longint hi);
      checks++;
      assert ((obs >= lo) && (obs <= hi)) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic clr_stats();
      n_smp = 0; n_mid = 0; n_bit = 0; first_smp = -1; last_smp = -1;
      gmin = 1 << 30; gmax = 0; orphan = 0; idx_err = 0;
      bit_t.delete(); mid_t.delete();
   endtask

   task automatic watch(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (sample_tick) begin
            n_smp++;
            if (last_smp >= 0) begin
               if (cyc - last_smp < gmin) gmin = cyc - last_smp;
               if (cyc - last_smp > gmax) gmax = cyc - last_smp;
            end
            if (first_smp < 0) first_smp = cyc;
            last_smp = cyc;
         end
         if (mid_tick) begin
            n_mid++;
            mid_t.push_back(cyc);
            if (!sample_tick) orphan++;
            if (sample_idx != 4'd8) idx_err++;
         end
         if (bit_tick) begin
            n_bit++;
            bit_t.push_back(cyc);
            if (!sample_tick) orphan++;
            if (sample_idx != 4'd0) idx_err++;
         end
      end
   endtask

   task automatic wait_mid(input int budget, output bit hit);
      hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge clk);
         if (mid_tick) hit = 1'b1;
      end
   endtask

   function automatic int q_at(input int q[$], input int k);
      return (q.size() > k) ? q[k] : -1000000;
   endfunction

   initial begin
      reset = 1'b1; enable = 1'b0; sync = 1'b0; baud_select = 3'b111;
      repeat (3) @(negedge clk);
      chk("rst_sample_tick", sample_tick, 0);
      chk("rst_mid_tick", mid_tick, 0);
      chk("rst_bit_tick", bit_tick, 0);
      chk("rst_sample_idx", sample_idx, 0);
      reset = 1'b0;
      clr_stats();
      watch(20);
      chk("idle_no_ticks", n_smp + n_mid + n_bit, 0);

      // 115200 baud, 10 bits from RUN entry
      enable = 1'b1;
      e = cyc + 1;
      clr_stats();
      watch(8700);
      chk("t1_samples", n_smp, 160);
      chk("t1_bits", n_bit, 10);
      chk("t1_mids", n_mid, 10);
      chk_rng("t1_gap_min", gmin, 54, 55);
      chk_rng("t1_gap_max", gmax, 54, 55);
      chk_rng("t1_first_sample", first_smp - e, 54, 55);
      chk_rng("t1_first_bit", q_at(bit_t, 0) - e, 867, 869);
      chk_rng("t1_span_10_bits", q_at(bit_t, 9) - e, 8680, 8682);
      chk("t1_idx_align", idx_err, 0);
      chk("t1_orphan", orphan, 0);

      // 1200 baud, first three samples
      enable = 1'b0;
      @(negedge clk);
      baud_select = 3'b001;
      enable = 1'b1;
      e = cyc + 1;
      clr_stats();
      watch(15700);
      chk("t2_samples", n_smp, 3);
      chk_rng("t2_first_sample", first_smp - e, 5208, 5209);
      chk_rng("t2_gap_min", gmin, 5208, 5209);
      chk_rng("t2_gap_max", gmax, 5208, 5209);
      chk("t2_no_mid_bit", n_mid + n_bit, 0);
      chk("t2_idx", sample_idx, 3);

      // sync re-phase at 115200
      enable = 1'b0;
      @(negedge clk);
      baud_select = 3'b111;
      enable = 1'b1;
      watch(301);
      sync = 1'b1;
      s = cyc + 1;
      @(negedge clk);
      sync = 1'b0;
      chk("t3_idx_after_sync", sample_idx, 0);
      chk("t3_tick_after_sync", sample_tick, 0);
      clr_stats();
      watch(900);
      chk_rng("t3_first_sample", first_smp - s, 54, 55);
      chk_rng("t3_mid", q_at(mid_t, 0) - s, 433, 435);
      chk_rng("t3_bit", q_at(bit_t, 0) - s, 867, 869);
      chk("t3_orphan", orphan, 0);

      // 9600 -> 115200 change mid-bit
      enable = 1'b0;
      @(negedge clk);
      baud_select = 3'b011;
      enable = 1'b1;
      watch(50);
      sync = 1'b1;
      s = cyc + 1;
      @(negedge clk);
      sync = 1'b0;
      clr_stats();
      watch(3000);
      baud_select = 3'b111;
      watch(8400);
      chk_rng("t4_mid_old_rate", q_at(mid_t, 0) - s, 5208, 5210);
      chk_rng("t4_bit_old_rate", q_at(bit_t, 0) - s, 10416, 10418);
      chk_rng("t4_bit_new_rate", q_at(bit_t, 1) - q_at(bit_t, 0), 867, 869);
      chk("t4_idx_align", idx_err, 0);

      // async reset pulse while a mid_tick is showing
      wait_mid(1000, found);
      chk("t5_mid_seen", found, 1);
      #1 reset = 1'b1;
      #1;
      chk("t5_async_sample_tick", sample_tick, 0);
      chk("t5_async_mid_tick", mid_tick, 0);
      chk("t5_async_bit_tick", bit_tick, 0);
      chk("t5_async_sample_idx", sample_idx, 0);
      #2 reset = 1'b0;
      e = cyc + 1;
      clr_stats();
      watch(100);
      chk_rng("t5_first_sample", first_smp - e, 54, 55);

      // enable drop mid-bit, then restart
      wait_mid(1000, found);
      chk("t6_mid_seen", found, 1);
      enable = 1'b0;
      @(negedge clk);
      chk("t6_idx_cleared", sample_idx, 0);
      chk("t6_tick_on_edge", sample_tick, 0);
      clr_stats();
      watch(1000);
      chk("t6_no_ticks", n_smp + n_mid + n_bit, 0);
      enable = 1'b1;
      e = cyc + 1;
      clr_stats();
      watch(900);
      chk_rng("t6_restart_mid", q_at(mid_t, 0) - e, 433, 435);
      chk_rng("t6_restart_bit", q_at(bit_t, 0) - e, 867, 869);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
